// File: rtl/fm_mod.sv
// FM modulator: 32-bit NCO driven by carrier + scaled modulation, quarter-wave sine ROM to 12-bit offset binary.
// Latency: phase issued in cycle t appears on data_out at t+3; mod_valid at t reaches the output at t+6.
// Backpressure: none; en gates sample issue and phase advance, out_valid is en delayed by three cycles.
module fm_mod #(
    parameter logic [31:0] CARRIER_FCW = 32'd171798692,
    parameter logic [31:0] DEV_K       = 32'd429497,
    parameter int          DEV_SHIFT   = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        phase_rst,
    input  logic [11:0] mod_in,
    input  logic        mod_valid,
    output logic [11:0] data_out,
    output logic        out_valid
);

    localparam logic signed [127:0] PI_Q60     = 128'sh3243F6A8885A308D;
    localparam logic signed [127:0] HALF_Q60   = 128'sh0800000000000000;
    localparam logic signed [127:0] AMPL       = 128'sd2047;

    // round(2047*sin(pi*(2k+1)/1024)) evaluated at elaboration with a Q60 Taylor series,
    // so the table needs no external hex file.
    function automatic logic [10:0] sine_entry(input int k);
        logic signed [127:0] x, x2, term, sum, div;
        x    = (PI_Q60 * 128'(2 * k + 1)) >>> 10;
        x2   = (x * x) >>> 60;
        term = x;
        sum  = x;
        for (int i = 1; i <= 12; i++) begin
            div  = 128'(2 * i * (2 * i + 1));
            term = -((term * x2) >>> 60) / div;
            sum  = sum + term;
        end
        return 11'((sum * AMPL + HALF_Q60) >>> 60);
    endfunction

    logic [10:0] rom [256];

    for (genvar k = 0; k < 256; k++) begin : g_rom
        localparam logic [10:0] ROM_VAL = sine_entry(k);
        assign rom[k] = ROM_VAL;
    end

    logic signed [11:0] mod_hold;
    logic signed [31:0] dev_prod;
    logic signed [31:0] dev_term;
    logic [31:0]        fcw_reg;
    logic [31:0]        phase_acc;

    logic [7:0]  ph_addr;
    logic [7:0]  ph_idx;

    logic        s1_vld;
    logic        s1_neg;
    logic [7:0]  s1_idx;
    logic        s2_vld;
    logic        s2_neg;
    logic [10:0] s2_rom;

    assign dev_prod = 32'(mod_hold) * signed'(DEV_K);
    assign dev_term = dev_prod >>> DEV_SHIFT;

    // Odd quadrants walk the quarter wave backwards; 255-a is the bitwise inverse.
    assign ph_addr = phase_acc[29:22];
    assign ph_idx  = phase_acc[30] ? ~ph_addr : ph_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            mod_hold  <= '0;
            fcw_reg   <= CARRIER_FCW;
            phase_acc <= '0;
            s1_vld    <= 1'b0;
            s1_neg    <= 1'b0;
            s1_idx    <= '0;
            s2_vld    <= 1'b0;
            s2_neg    <= 1'b0;
            s2_rom    <= '0;
            out_valid <= 1'b0;
            data_out  <= 12'd2048;
        end else begin
            if (mod_valid) begin
                mod_hold <= signed'(mod_in);
            end
            fcw_reg <= CARRIER_FCW + 32'(dev_term);

            if (phase_rst) begin
                phase_acc <= '0;
            end else if (en) begin
                phase_acc <= phase_acc + fcw_reg;
            end

            s1_vld <= en;
            if (en) begin
                s1_neg <= phase_acc[31];
                s1_idx <= ph_idx;
            end

            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_neg <= s1_neg;
                s2_rom <= rom[s1_idx];
            end

            // data_out holds its last sample through gaps in the stream.
            out_valid <= s2_vld;
            if (s2_vld) begin
                data_out <= s2_neg ? (12'd2048 - {1'b0, s2_rom})
                                   : (12'd2048 + {1'b0, s2_rom});
            end
        end
    end

endmodule
